// File: rtl/ca_nco_code_gen_pkg.sv
// Shared constants, types and helpers for the GPS C/A NCO code generator.
package ca_nco_code_gen_pkg;

  localparam int         CODE_LEN   = 1023;
  localparam logic [9:0] LFSR_INIT  = 10'h3FF;
  localparam logic [9:0] LAST_PHASE = 10'(CODE_LEN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SLEW = 1'b1
  } slew_state_e;

  // G2 output taps, numbered as register stages 1..10.
  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
  } prn_taps_t;

  // G2 phase-select taps for SV PRN 1..32 (index 0..31).
  function automatic prn_taps_t prn_taps(input logic [4:0] prn);
    case (prn)
      5'd0:  return {4'd2, 4'd6};
      5'd1:  return {4'd3, 4'd7};
      5'd2:  return {4'd4, 4'd8};
      5'd3:  return {4'd5, 4'd9};
      5'd4:  return {4'd1, 4'd9};
      5'd5:  return {4'd2, 4'd10};
      5'd6:  return {4'd1, 4'd8};
      5'd7:  return {4'd2, 4'd9};
      5'd8:  return {4'd3, 4'd10};
      5'd9:  return {4'd2, 4'd3};
      5'd10: return {4'd3, 4'd4};
      5'd11: return {4'd5, 4'd6};
      5'd12: return {4'd6, 4'd7};
      5'd13: return {4'd7, 4'd8};
      5'd14: return {4'd8, 4'd9};
      5'd15: return {4'd9, 4'd10};
      5'd16: return {4'd1, 4'd4};
      5'd17: return {4'd2, 4'd5};
      5'd18: return {4'd3, 4'd6};
      5'd19: return {4'd4, 4'd7};
      5'd20: return {4'd5, 4'd8};
      5'd21: return {4'd6, 4'd9};
      5'd22: return {4'd1, 4'd3};
      5'd23: return {4'd4, 4'd6};
      5'd24: return {4'd5, 4'd7};
      5'd25: return {4'd6, 4'd8};
      5'd26: return {4'd7, 4'd9};
      5'd27: return {4'd8, 4'd10};
      5'd28: return {4'd1, 4'd6};
      5'd29: return {4'd2, 4'd7};
      5'd30: return {4'd3, 4'd8};
      default: return {4'd4, 4'd9};
    endcase
  endfunction

  // C/A chip for a given G1/G2 state; stage n lives in bit n-1.
  function automatic logic ca_chip(input logic [9:0] g1, input logic [9:0] g2,
                                   input prn_taps_t taps);
    return g1[9] ^ g2[taps.s1 - 4'd1] ^ g2[taps.s2 - 4'd1];
  endfunction

  // Slew requests beyond one code period minus one chip are clamped.
  function automatic logic [9:0] sat_slew(input logic [10:0] chips);
    if (chips > 11'd1022) return 10'd1022;
    return chips[9:0];
  endfunction

endpackage

// File: rtl/ca_nco_code_gen_lfsr_pair.sv
// G1/G2 code LFSRs with PRN register, tap mux and current/next chip outputs.
module ca_nco_code_gen_lfsr_pair
  import ca_nco_code_gen_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_step,
  input  logic       i_reload,
  input  logic       i_prn_load,
  input  logic [4:0] i_prn,
  output logic       o_chip,
  output logic       o_chip_next,
  output logic [9:0] o_g1_state
);

  logic [9:0] r_g1, r_g2;
  logic [9:0] w_g1_next, w_g2_next;
  logic [4:0] r_prn;
  prn_taps_t  w_taps;

  // Next LFSR state: reload wins over a step; otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_g1_next = r_g1;
    w_g2_next = r_g2;
    if (i_reload) begin
      w_g1_next = LFSR_INIT;
      w_g2_next = LFSR_INIT;
    end else if (i_step) begin
      w_g1_next = {r_g1[8:0], r_g1[2] ^ r_g1[9]};
      w_g2_next = {r_g2[8:0], r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9]};
    end
  end

  // LFSR and PRN-select registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_g1  <= LFSR_INIT;
      r_g2  <= LFSR_INIT;
      r_prn <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_g1 <= w_g1_next;
      r_g2 <= w_g2_next;
      if (i_prn_load) r_prn <= i_prn;
    end
  end

  assign w_taps      = prn_taps(r_prn);
  assign o_chip      = ca_chip(r_g1, r_g2, w_taps);
  assign o_chip_next = ca_chip(w_g1_next, w_g2_next, w_taps);
  assign o_g1_state  = r_g1;

endmodule

// File: rtl/ca_nco_code_gen.sv
// GPS C/A code generator: NCO-driven chip rate, code-phase slew, early/prompt/late replicas.
module ca_nco_code_gen
  import ca_nco_code_gen_pkg::*;
#(
  parameter int NCO_WIDTH   = 32,
  parameter int EPL_SPACING = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [4:0]           prn,
  input  logic                 prn_load,
  input  logic [NCO_WIDTH-1:0] nco_step,
  input  logic [10:0]          slew_chips,
  input  logic                 slew_valid,
  output logic                 slew_ready,
  output logic                 early,
  output logic                 prompt,
  output logic                 late,
  output logic                 chip_tick,
  output logic [9:0]           code_phase,
  output logic                 epoch,
  output logic [9:0]           g1_state
);

  localparam int SR_LEN = 2 * EPL_SPACING + 1;

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  logic [NCO_WIDTH-1:0] r_acc;
  logic [NCO_WIDTH:0]   w_acc_sum;
  logic                 r_half_phase;
  logic [9:0]           r_code_phase;
  logic [9:0]           r_count, w_count_next;
  slew_state_e          r_state, w_state_next;
  logic [SR_LEN-1:0]    r_sr;
  logic                 r_chip_tick, r_epoch;
  logic                 w_accept, w_slew_step, w_slew_last, w_nco_run;
  logic                 w_half_tick, w_nco_adv, w_step, w_wrap;
  logic                 w_chip, w_chip_next;

  // Reset synchroniser: assertion is immediate, release waits two clocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // prn_load outranks slewing, which outranks the NCO.
  assign w_accept    = slew_valid && (r_state == ST_IDLE) && !prn_load && (slew_chips != 11'd0);
  assign w_slew_step = (r_state == ST_SLEW) && !prn_load;
  assign w_slew_last = w_slew_step && (r_count == 10'd1);
  assign w_nco_run   = enable && (r_state == ST_IDLE) && !prn_load && !w_accept;
  assign w_acc_sum   = {1'b0, r_acc} + {1'b0, nco_step};
  assign w_half_tick = w_nco_run && w_acc_sum[NCO_WIDTH];
  assign w_nco_adv   = w_half_tick && r_half_phase;
  assign w_step      = w_nco_adv || w_slew_step;
  assign w_wrap      = w_step && (r_code_phase == LAST_PHASE);

  // Slew FSM next-state and remaining-chip count.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    if (prn_load) begin
      w_state_next = ST_IDLE;
      w_count_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          w_state_next = ST_SLEW;
          w_count_next = sat_slew(slew_chips);
        end
        ST_SLEW: begin
          w_count_next = r_count - 10'd1;
          if (r_count == 10'd1) w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Slew FSM state register.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Phase accumulator and half-chip phase; frozen while slewing or disabled.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_acc        <= '0;
      r_half_phase <= 1'b0;
    end else if (prn_load) begin
      r_acc        <= '0;
      r_half_phase <= 1'b0;
    end else if (w_nco_run) begin
      r_acc <= w_acc_sum[NCO_WIDTH-1:0];
      if (w_acc_sum[NCO_WIDTH]) r_half_phase <= !r_half_phase;
    end
  end

  // Code phase counter plus chip_tick/epoch, aligned with the new phase.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_code_phase <= '0;
      r_chip_tick  <= 1'b0;
      r_epoch      <= 1'b0;
    end else begin
      r_chip_tick <= w_nco_adv;
      r_epoch     <= w_nco_adv && w_wrap;
      if (prn_load)    r_code_phase <= '0;
      else if (w_wrap) r_code_phase <= '0;
      else if (w_step) r_code_phase <= r_code_phase + 10'd1;
    end
  end

  // Early/prompt/late delay line; slew exit floods it with the new chip.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n)         r_sr <= '0;
    else if (prn_load)    r_sr <= '0;
    else if (w_slew_last) r_sr <= {SR_LEN{w_chip_next}};
    else if (w_half_tick) r_sr <= {r_sr[SR_LEN-2:0], w_chip};
  end

  ca_nco_code_gen_lfsr_pair u_lfsr (
    .clock       (clock),
    .reset_n     (w_rst_n),
    .i_step      (w_step),
    .i_reload    (prn_load || w_wrap),
    .i_prn_load  (prn_load),
    .i_prn       (prn),
    .o_chip      (w_chip),
    .o_chip_next (w_chip_next),
    .o_g1_state  (g1_state)
  );

  assign slew_ready = (r_state == ST_IDLE);
  assign early      = r_sr[0];
  assign prompt     = r_sr[EPL_SPACING];
  assign late       = r_sr[2*EPL_SPACING];
  assign chip_tick  = r_chip_tick;
  assign code_phase = r_code_phase;
  assign epoch      = r_epoch;

endmodule

// File: tb/tb_ca_nco_code_gen.sv
// Directed bench for ca_nco_code_gen: PRN chips, epoch, EPL spacing, slew, load abort, async reset.
module tb_ca_nco_code_gen;

  logic        clock = 1'b0;
  logic        reset_n, enable, prn_load, slew_valid;
  logic [4:0]  prn;
  logic [31:0] nco_step;
  logic [10:0] slew_chips;

  logic       slew_ready, early, prompt, late, chip_tick, epoch;
  logic [9:0] code_phase, g1_state;
  logic       s2_slew_ready, s2_early, s2_prompt, s2_late, s2_chip_tick, s2_epoch;
  logic [9:0] s2_code_phase, s2_g1_state;

  int n_vec = 0;
  int n_err = 0;

  // First 10 chips of PRN 1..32 in octal, from the ICD code table.
  localparam logic [9:0] FIRST10 [32] = '{
    10'o1440, 10'o1620, 10'o1710, 10'o1744, 10'o1133, 10'o1455, 10'o1131, 10'o1454,
    10'o1626, 10'o1504, 10'o1642, 10'o1750, 10'o1764, 10'o1772, 10'o1775, 10'o1776,
    10'o1156, 10'o1467, 10'o1633, 10'o1715, 10'o1746, 10'o1763, 10'o1063, 10'o1706,
    10'o1743, 10'o1761, 10'o1770, 10'o1774, 10'o1127, 10'o1453, 10'o1625, 10'o1712};

  always #5 clock = ~clock;

  ca_nco_code_gen #(.NCO_WIDTH(32), .EPL_SPACING(1)) u_dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .prn(prn), .prn_load(prn_load),
    .nco_step(nco_step), .slew_chips(slew_chips), .slew_valid(slew_valid),
    .slew_ready(slew_ready), .early(early), .prompt(prompt), .late(late),
    .chip_tick(chip_tick), .code_phase(code_phase), .epoch(epoch), .g1_state(g1_state));

  ca_nco_code_gen #(.NCO_WIDTH(32), .EPL_SPACING(2)) u_dut_s2 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .prn(prn), .prn_load(prn_load),
    .nco_step(nco_step), .slew_chips(slew_chips), .slew_valid(slew_valid),
    .slew_ready(s2_slew_ready), .early(s2_early), .prompt(s2_prompt), .late(s2_late),
    .chip_tick(s2_chip_tick), .code_phase(s2_code_phase), .epoch(s2_epoch),
    .g1_state(s2_g1_state));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_prn(input logic [4:0] p);
    prn      = p;
    prn_load = 1'b1;
    tick();
    prn_load = 1'b0;
  endtask

  // Gather prompt at each chip_tick, MSB first.
  task automatic collect(input string tag, input int n, output logic [15:0] bits);
    int got    = 0;
    int budget = 0;
    bits = '0;
    while (got < n && budget < 20 * n + 40) begin
      tick();
      budget++;
      if (chip_tick) begin
        bits = {bits[14:0], prompt};
        got++;
      end
    end
    check({tag, "_wait"}, got, n);
  endtask

  // Issue one slew and count cycles with slew_ready low.
  task automatic do_slew(input logic [10:0] chips, output int lows, output bit saw_tick);
    slew_chips = chips;
    slew_valid = 1'b1;
    tick();
    slew_valid = 1'b0;
    slew_chips = '0;
    lows     = 0;
    saw_tick = 1'b0;
    while (!slew_ready && lows < 3000) begin
      lows++;
      if (chip_tick) saw_tick = 1'b1;
      tick();
    end
  endtask

  logic [15:0] bits;
  int          lows, cyc, ticks;
  bit          saw_tick, got_epoch;
  logic        e1 [64], p1 [64], l1 [64], e2 [64], p2 [64], l2 [64];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; prn = '0; prn_load = 1'b0;
    nco_step = 32'h8000_0000; slew_chips = '0; slew_valid = 1'b0;
    repeat (3) tick();
    check("rst_slew_ready", slew_ready, 1);
    check("rst_epl", {early, prompt, late}, 3'b000);
    check("rst_tick_epoch", {chip_tick, epoch}, 2'b00);
    check("rst_phase", code_phase, 0);
    check("rst_g1", g1_state, 10'h3FF);
    reset_n = 1'b1;
    repeat (3) tick();

    // Disabled NCO stays at phase 0; then PRN 1 chips.
    load_prn(5'd0);
    repeat (20) tick();
    check("frozen_phase", code_phase, 0);
    check("frozen_g1", g1_state, 10'h3FF);
    enable = 1'b1;
    collect("prn1", 10, bits);
    check("prn1_first10", bits[9:0], 10'o1440);

    // Epoch after a full code period, then the code restarts cleanly.
    load_prn(5'd0);
    ticks = 0; cyc = 0; got_epoch = 1'b0;
    while (!got_epoch && cyc < 6000) begin
      tick();
      cyc++;
      if (chip_tick) ticks++;
      if (epoch) begin
        got_epoch = 1'b1;
        check("epoch_phase", code_phase, 0);
        check("epoch_with_tick", chip_tick, 1);
      end
    end
    check("epoch_after_ticks", ticks, 1023);
    collect("wrap", 10, bits);
    check("prn1_after_wrap", bits[9:0], 10'o1440);

    // All 32 PRNs.
    for (int p = 0; p < 32; p++) begin
      load_prn(5'(p));
      collect($sformatf("prn%0d", p + 1), 10, bits);
      check($sformatf("prn%0d_first10", p + 1), bits[9:0], FIRST10[p]);
    end

    // Quarter-scale step: half tick every 4 clocks, chip every 8.
    nco_step = 32'h4000_0000;
    load_prn(5'd0);
    collect("slow", 1, bits);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!chip_tick && cyc < 100);
    check("tick_interval", cyc, 8);
    nco_step = 32'h8000_0000;

    // EPL delays for spacing 1 and 2.
    load_prn(5'd1);
    for (int t = 0; t < 64; t++) begin
      tick();
      e1[t] = early;    p1[t] = prompt;    l1[t] = late;
      e2[t] = s2_early; p2[t] = s2_prompt; l2[t] = s2_late;
    end
    for (int t = 8; t < 64; t++) begin
      check("epl1_prompt", p1[t], e1[t-2]);
      check("epl1_late",   l1[t], e1[t-4]);
      check("epl2_prompt", p2[t], e2[t-4]);
      check("epl2_late",   l2[t], e2[t-8]);
    end

    // Slew 1022 from phase 0, then the next NCO chip wraps with epoch.
    enable = 1'b0;
    load_prn(5'd0);
    do_slew(11'd1022, lows, saw_tick);
    check("slew1022_lows", lows, 1022);
    check("slew1022_phase", code_phase, 1022);
    check("slew1022_no_tick", saw_tick, 0);
    check("slew1022_epl_equal", (early == prompt) && (prompt == late), 1);
    enable = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!chip_tick && cyc < 100);
    check("slew_wrap_phase", code_phase, 0);
    check("slew_wrap_epoch", epoch, 1);
    enable = 1'b0;

    // Oversized slew saturates.
    load_prn(5'd0);
    do_slew(11'd2000, lows, saw_tick);
    check("slew2000_lows", lows, 1022);
    check("slew2000_phase", code_phase, 1022);

    // Short slew on PRN 5 lands on chip 3; prompt then follows chips 3..9.
    load_prn(5'd4);
    do_slew(11'd3, lows, saw_tick);
    check("slew3_lows", lows, 3);
    check("slew3_phase", code_phase, 3);
    check("slew3_epl", {early, prompt, late}, 3'b111);
    enable = 1'b1;
    collect("slew3", 7, bits);
    check("slew3_chips", bits[6:0], 7'b1011011);
    enable = 1'b0;

    // Zero-length slew is a no-op.
    load_prn(5'd0);
    slew_chips = '0; slew_valid = 1'b1;
    tick();
    slew_valid = 1'b0;
    check("slew0_ready", slew_ready, 1);
    check("slew0_phase", code_phase, 0);

    // Slew request coinciding with prn_load is not accepted.
    prn = 5'd0; prn_load = 1'b1; slew_valid = 1'b1; slew_chips = 11'd5;
    tick();
    prn_load = 1'b0; slew_valid = 1'b0; slew_chips = '0;
    check("load_vs_slew_ready", slew_ready, 1);
    tick();
    check("load_vs_slew_phase", code_phase, 0);

    // prn_load aborts a slew in progress.
    load_prn(5'd0);
    slew_chips = 11'd1022; slew_valid = 1'b1;
    tick();
    slew_valid = 1'b0; slew_chips = '0;
    repeat (100) tick();
    check("abort_mid_ready", slew_ready, 0);
    check("abort_mid_phase", code_phase, 100);
    load_prn(5'd0);
    check("abort_ready", slew_ready, 1);
    check("abort_phase", code_phase, 0);
    check("abort_g1", g1_state, 10'h3FF);
    tick();
    check("abort_hold", {slew_ready, code_phase}, {1'b1, 10'd0});

    // Asynchronous reset mid-run, then resume from phase 0 on PRN 1.
    enable = 1'b1;
    load_prn(5'd3);
    repeat (37) tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_epl", {early, prompt, late}, 3'b000);
    check("async_tick_epoch", {chip_tick, epoch}, 2'b00);
    check("async_ready", slew_ready, 1);
    check("async_phase", code_phase, 0);
    check("async_g1", g1_state, 10'h3FF);
    #3 reset_n = 1'b1;
    collect("post_reset", 10, bits);
    check("post_reset_first10", bits[9:0], 10'o1440);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
